// File: rtl/smul_share_arbiter.sv
// Round-robin front end sharing one pipelined signed multiplier among NREQ
// requesters; results leave in grant order, tagged with the requester index.
module smul_share_arbiter #(
    parameter int DATAWIDTH = 8,
    parameter int NREQ      = 4,
    parameter int LAT       = 2,
    localparam int IDW      = $clog2(NREQ)
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*DATAWIDTH-1:0] a_in,
    input  logic [NREQ*DATAWIDTH-1:0] b_in,
    output logic [NREQ-1:0]           gnt,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [IDW-1:0]            res_id,
    output logic [2*DATAWIDTH-1:0]    res_data,
    output logic                      busy
);

    localparam int DW = DATAWIDTH;

    logic                 adv;
    logic                 gnt_any;
    logic [IDW-1:0]       gidx;
    logic [IDW-1:0]       ptr;
    logic [DW-1:0]        sel_a, sel_b;
    logic [LAT:1]         vld_pipe;
    logic [IDW-1:0]       id_pipe [1:LAT];

    // Sign-extend both operands to full product width so an unsigned
    // multiply yields the exact two's-complement product.
    function automatic logic [2*DW-1:0] smul(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return {{DW{a[DW-1]}}, a} * {{DW{b[DW-1]}}, b};
    endfunction

    assign adv = !(res_valid && !res_ready);

    always_comb begin : arb
        logic [IDW-1:0] idx;
        int             sum;
        gnt_any = 1'b0;
        gidx    = '0;
        idx     = '0;
        sum     = 0;
        for (int k = 0; k < NREQ; k++) begin
            sum = int'(ptr) + k;
            if (sum >= NREQ) sum = sum - NREQ;
            idx = IDW'(sum);
            if (!gnt_any && req[idx]) begin
                gnt_any = 1'b1;
                gidx    = idx;
            end
        end
        if (!adv || !Rst) gnt_any = 1'b0;
    end

    always_comb begin
        gnt = '0;
        if (gnt_any) gnt[gidx] = 1'b1;
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gidx == IDW'(i)) begin
                sel_a = a_in[i*DW +: DW];
                sel_b = b_in[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            ptr <= '0;
        end else if (gnt_any) begin
            ptr <= (gidx == IDW'(NREQ-1)) ? '0 : gidx + 1'b1;
        end
    end

    // Valid bits shift every advancing edge so bubbles keep issue spacing;
    // tags only move alongside a valid op, so idle stages hold their last tag.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            vld_pipe <= '0;
            for (int s = 1; s <= LAT; s++) id_pipe[s] <= '0;
        end else if (adv) begin
            vld_pipe[1] <= gnt_any;
            if (gnt_any) id_pipe[1] <= gidx;
            for (int s = 2; s <= LAT; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                if (vld_pipe[s-1]) id_pipe[s] <= id_pipe[s-1];
            end
        end
    end

    generate
        if (LAT == 1) begin : g_lat1
            logic [2*DW-1:0] prod_q;
            always_ff @(posedge Clk or negedge Rst) begin
                if (!Rst) prod_q <= '0;
                else if (gnt_any) prod_q <= smul(sel_a, sel_b);
            end
            assign res_data = prod_q;
        end else begin : g_latn
            // Operands registered first; multiply happens between stage 1 and 2,
            // later stages only carry the product.
            logic [DW-1:0]   op_a, op_b;
            logic [2*DW-1:0] prod_pipe [2:LAT];
            always_ff @(posedge Clk or negedge Rst) begin
                if (!Rst) begin
                    op_a <= '0;
                    op_b <= '0;
                    for (int s = 2; s <= LAT; s++) prod_pipe[s] <= '0;
                end else if (adv) begin
                    if (gnt_any) begin
                        op_a <= sel_a;
                        op_b <= sel_b;
                    end
                    if (vld_pipe[1]) prod_pipe[2] <= smul(op_a, op_b);
                    for (int s = 3; s <= LAT; s++) begin
                        if (vld_pipe[s-1]) prod_pipe[s] <= prod_pipe[s-1];
                    end
                end
            end
            assign res_data = prod_pipe[LAT];
        end
    endgenerate

    assign res_valid = vld_pipe[LAT];
    assign res_id    = id_pipe[LAT];
    assign busy      = |vld_pipe;

endmodule

// File: doc/smul_share_arbiter.md
# smul_share_arbiter

Round-robin scheduler that shares one pipelined signed multiplier (SMUL-style, 2×DATAWIDTH exact product) among NREQ requesters inside a generated datapath. It accepts at most one operand pair per cycle and tags each product with its requester index. It returns products in issue order over a valid/ready result port. Generated circuits instantiate it when list scheduling assigns several multiplications to a single multiplier resource.

## Interface

- DATAWIDTH, 8, operand width in bits; operands are signed two's complement.
- NREQ, 4, number of requesters (2..16).
- LAT, 2, multiplier pipeline depth in cycles (≥1).
- IDW, clog2(NREQ), width of the requester tag (derived, not overridden).

Ports:

- Clk  in  1  clock; all state on rising edge.
- Rst  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester request; held high with stable operands until granted.
- a_in  in  NREQ*DATAWIDTH  operand A; requester i occupies bits [i*DATAWIDTH +: DATAWIDTH].
- b_in  in  NREQ*DATAWIDTH  operand B, same packing.
- gnt  out  NREQ  one-hot acceptance; combinational; operands of the granted requester are sampled on this cycle's edge.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result when high with res_valid.
- res_id  out  IDW  requester index of current result.
- res_data  out  2*DATAWIDTH  signed product a*b, exact, sign-extended.
- busy  out  1  any pipeline stage holds a valid operation.

## Operation

- Pipeline advance: adv = !(res_valid && !res_ready). When adv=0, every stage, the pointer and all outputs hold, and gnt = 0.
- Arbitration: round-robin pointer ptr (IDW bits). Search starts at ptr and moves upward with wrap-around. The first i with req[i]=1 gets gnt[i]=1, only if adv=1 and Rst=1. At most one gnt bit is high.
- On a granted edge, ptr ← (i+1) mod NREQ, and stage 1 captures {valid=1, id=i, a_i, b_i}. With no grant, ptr is unchanged and stage 1 captures valid=0 (bubble).
- Stages 2..LAT shift valid/id/partial data forward on each adv=1 edge. The product is computed as signed DATAWIDTH×DATAWIDTH → 2*DATAWIDTH with no truncation or saturation. The last stage drives res_valid/res_id/res_data directly from registers.
- Bubbles propagate; a bubble in the last stage gives res_valid=0. Bubbles do not collapse while adv=1, so spacing between issues is preserved.
- A requester holding req after its grant may be granted again only after the pointer has passed all other active requesters. Fairness bound: a waiting requester is granted within NREQ grant opportunities.
- res_data/res_id are don't-care when res_valid=0. The implementation holds the last value; the bench does not check them.
- busy = OR of all stage valid bits, including the output stage.
- Reset (Rst low, asynchronous): all valid bits 0, ptr=0, res_id=0, res_data=0, res_valid=0, busy=0. gnt is forced to 0 while Rst is low. In-flight operations are discarded, not replayed.

## Timing

- Issue latency: request granted in cycle t → res_valid=1 in cycle t+LAT, given no stall in between.
- Throughput: one issue per cycle while adv=1, regardless of requester mix.
- Stall: each cycle with res_valid && !res_ready extends the latency of every in-flight op by one cycle.
- Same-cycle accept and issue: a res_ready=1 handshake and a new grant occur together without a bubble.
- Results leave in issue (grant) order; no reordering.
- req changes take effect in the same cycle, because gnt is combinational from req, ptr and adv. A req dropped in the same cycle as its grant is a protocol violation and the bench does not drive it.
- Reset deassertion: the first grant is possible in the first cycle after Rst rises; ptr=0.

## Test plan

- Single op, defaults: req[0]=1, a=-3, b=5 at cycle t → gnt=0001 in t; res_valid=1 in t+2 with res_id=0, res_data=16'hFFF1 (-15); busy high for cycles t+1..t+2.
- All four requests held high with res_ready=1 → grants 0,1,2,3,0,1… one per cycle; res_id sequence 0,1,2,3,0… starting 2 cycles after the first grant; no gaps.
- Backpressure: pipeline full, res_ready=0 for 3 cycles → gnt=0, and res_valid/res_id/res_data stable across all three cycles. After res_ready returns, the full issue order is preserved with no lost or duplicated results.
- Extremes: (-128)×(-128) → 16'h4000; (-128)×127 → 16'hC080; 0×(-1) → 16'h0000; 127×127 → 16'h3F01.
- Pointer wrap and fairness: only req[1] and req[3] held → grants alternate 1,3,1,3. Then with req[0] also high right after a grant to 3, the next grant is 0, followed by 1.
- Mid-flight reset: two ops in flight, Rst pulled low between edges → res_valid and busy go 0 immediately. After release, ptr=0, no stale results appear, and a fresh req[2] returns res_id=2 after LAT cycles.
